// File: rtl/axis_merge_pkg.sv
// Shared types and helpers for the AXI4-Stream BRAM merger: FSM states,
// operand-select mode encodings and the buffer address-width function.
package axis_merge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    PROCESS = 2'd2,
    SEND    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_CONST = 2'b01,
    MODE_BRAM  = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic uses_const(input mode_e m);
    return (m == MODE_CONST) || (m == MODE_BOTH);
  endfunction

  function automatic logic uses_bram(input mode_e m);
    return (m == MODE_BRAM) || (m == MODE_BOTH);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port inferred RAM: one write port, one read port with a
// registered output that holds its value while rd_en_i is low.
module sdp_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_bram_merger.sv
// Store-and-forward AXI4-Stream packet processor: buffers one packet, adds a
// latched constant and/or BRAM words in place, then streams the result out.
module axis_bram_merger
  import axis_merge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter logic [31:0] BRAM_BASE  = 32'd0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  input  logic [1:0]                mode,
  input  logic [DATA_WIDTH-1:0]     add_const,
  output logic [31:0]               bram_addrb,
  output logic                      bram_enb,
  output logic [DATA_WIDTH/8-1:0]   bram_web,
  output logic [DATA_WIDTH-1:0]     bram_dinb,
  input  logic [DATA_WIDTH-1:0]     bram_doutb,
  output logic                      busy,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    pkt_len
);

  localparam int unsigned AW      = addr_w(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0]   BYTES   = 32'(DATA_WIDTH / 8);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] const_q, const_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         len_q, len_d;
  logic                  overflow_q, overflow_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;

  logic                  buf_we, buf_re;
  logic [AW-1:0]         buf_waddr, buf_raddr;
  logic [DATA_WIDTH-1:0] buf_wdata, buf_rdata, merged;
  logic                  bram_en;
  logic                  s_fire, m_fire;

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (AW)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (buf_waddr),
    .wr_data_i (buf_wdata),
    .rd_en_i   (buf_re),
    .rd_addr_i (buf_raddr),
    .rd_data_o (buf_rdata)
  );

  assign S_AXIS_TREADY = !reset && ((state_q == IDLE) || (state_q == STORE));
  assign s_fire        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign m_fire        = m_valid_q && M_AXIS_TREADY;

  // Buffer word and BRAM word both arrive one cycle after their read was issued
  assign merged = buf_rdata
                + (uses_const(mode_q) ? const_q : '0)
                + (uses_bram(mode_q) ? bram_doutb : '0);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    const_d    = const_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    buf_we     = 1'b0;
    buf_waddr  = '0;
    buf_wdata  = S_AXIS_TDATA;
    buf_re     = 1'b0;
    buf_raddr  = '0;
    bram_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_fire) begin
          buf_we     = 1'b1;
          mode_d     = mode_e'(mode);
          const_d    = add_const;
          overflow_d = 1'b0;
          cnt_d      = CW'(1);
          idx_d      = '0;
          if (S_AXIS_TLAST) begin
            len_d   = CW'(1);
            state_d = PROCESS;
          end else begin
            state_d = STORE;
          end
        end
      end
      STORE: begin
        if (s_fire) begin
          if (cnt_q < DEPTH_C) begin
            buf_we    = 1'b1;
            buf_waddr = cnt_q[AW-1:0];
            cnt_d     = cnt_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
          if (S_AXIS_TLAST) begin
            len_d   = cnt_d;
            idx_d   = '0;
            state_d = PROCESS;
          end
        end
      end
      PROCESS: begin
        // Read beat idx while writing back beat idx-1: N reads plus one drain cycle
        if (idx_q < len_q) begin
          buf_re    = 1'b1;
          buf_raddr = idx_q[AW-1:0];
          bram_en   = uses_bram(mode_q);
        end
        if (idx_q != '0) begin
          buf_we    = 1'b1;
          buf_waddr = AW'(idx_q - CW'(1));
          buf_wdata = merged;
        end
        if (idx_q == len_q) begin
          idx_d   = '0;
          state_d = SEND;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      SEND: begin
        if (m_fire) m_valid_d = 1'b0;
        // The RAM output register is the output stage; it only advances when free
        if ((!m_valid_q || M_AXIS_TREADY) && (idx_q < len_q)) begin
          buf_re    = 1'b1;
          buf_raddr = idx_q[AW-1:0];
          idx_d     = idx_q + CW'(1);
          m_valid_d = 1'b1;
          m_last_d  = ((idx_q + CW'(1)) == len_q);
        end
        if (m_fire && m_last_q) begin
          m_last_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_PASS;
      const_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      overflow_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      const_q    <= const_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  assign M_AXIS_TDATA  = m_valid_q ? buf_rdata : '0;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign bram_enb      = bram_en;
  assign bram_addrb    = ((state_q == PROCESS) && (idx_q < len_q))
                       ? BRAM_BASE + 32'(idx_q) * BYTES : 32'd0;
  assign bram_web      = '0;
  assign bram_dinb     = '0;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;
  assign pkt_len       = len_q;

endmodule
